// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Contents:
//   XLEN          : datapath width (32)
//   NOP_INSTR     : addi x0,x0,0, used as IR reset/flush value
//   fetch_state_e : IDLE / WAIT / FAULT
//   word_align    : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// rtl/fetch_wait_ctr.sv - loadable down-counter timing instruction-memory wait states
//
// Ports:
//   clk        : core clock, rising edge
//   reset_n    : asynchronous active-low reset
//   clear_i    : drop any count in progress (highest priority)
//   load_i     : load load_val_i
//   load_val_i : wait-state count to load (1..7)
//   done_o     : high in the last wait cycle (count == 1)
module fetch_wait_ctr (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic       done_o
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 3'd0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 3'd0) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 3'd1);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, IR and memory wait-state handshake
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : fetch at a misaligned PC enters sticky FAULT (fetch_fault=1)
//   undefined : PC[1:0] forced to 00 on imem_addr/fetch_pc, fetch_fault tied 0
//
// Ports:
//   clk, reset_n        : core clock, asynchronous active-low reset
//   fetch_req           : control FSM requests a fetch at the current PC
//   flush               : abort in-flight fetch, IR returns to NOP
//   pc_we, pc_next      : load a new PC (any state)
//   imem_addr           : byte address to instruction memory
//   instr_rdata         : word returned by instruction memory
//   instr               : instruction register
//   instr_valid         : one-cycle pulse when IR is newly loaded
//   fetch_pc            : address of the instruction in IR
//   fetch_pc_plus4      : fetch_pc + 4 (wraps)
//   fetch_busy          : fetch in flight, fetch_req ignored
//   fetch_fault         : misaligned-PC fault
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 0,
  parameter logic [31:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic [31:0] imem_addr,
  input  logic [31:0] instr_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_fault
);

  import fetch_pkg::*;

  localparam bit ZERO_LAT = (MEM_LATENCY == 0);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc4_q;
  logic            valid_q;

  logic [XLEN-1:0] pc_eff;
  logic            misaligned;
  logic            accept;
  logic            issue;
  logic            capture;
  logic [XLEN-1:0] cap_addr;
  logic            ctr_done;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign pc_eff     = pc_q;
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign pc_eff     = word_align(pc_q);
  assign misaligned = 1'b0;
`endif

  // With zero wait states a request in the pulse cycle would give back-to-back
  // instr_valid pulses, so that cycle is treated as still busy.
  assign accept = (state_q == ST_IDLE) && fetch_req && !flush &&
                  !(ZERO_LAT && valid_q);
  assign issue  = accept && !misaligned;

  always_comb begin
    capture  = 1'b0;
    cap_addr = addr_q;
    if (ZERO_LAT) begin
      capture  = issue;
      cap_addr = pc_eff;
    end else begin
      capture  = (state_q == ST_WAIT) && ctr_done && !flush;
    end
  end

  generate
    if (MEM_LATENCY > 0) begin : g_wait
      fetch_wait_ctr u_wait_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (flush),
        .load_i     (issue),
        .load_val_i (3'(MEM_LATENCY)),
        .done_o     (ctr_done)
      );
    end else begin : g_no_wait
      assign ctr_done = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              state_d = ST_FAULT;
            end else if (!ZERO_LAT) begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ctr_done) begin
            state_d = ST_IDLE;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_FAULT: begin
          if (pc_we && (pc_next[1:0] == 2'b00)) begin
            state_d = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    imem_addr  = pc_eff;
    fetch_busy = 1'b0;
    if (state_q == ST_WAIT) begin
      imem_addr  = addr_q;
      fetch_busy = 1'b1;
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_fault = (state_q == ST_FAULT);
`else
    fetch_fault = 1'b0;
`endif
  end

  // Datapath registers. addr_q freezes the fetch address so pc_we during WAIT
  // cannot disturb the word being fetched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      ir_q        <= NOP_INSTR;
      fetch_pc_q  <= RESET_PC;
      fetch_pc4_q <= RESET_PC + 32'd4;
      valid_q     <= 1'b0;
    end else begin
      if (pc_we) begin
        pc_q <= pc_next;
      end
      if (issue) begin
        addr_q <= pc_eff;
      end
      valid_q <= capture;
      if (flush) begin
        ir_q <= NOP_INSTR;
      end else if (capture) begin
        ir_q        <= instr_rdata;
        fetch_pc_q  <= cap_addr;
        fetch_pc4_q <= cap_addr + 32'd4;
      end
    end
  end

  assign instr          = ir_q;
  assign instr_valid    = valid_q;
  assign fetch_pc       = fetch_pc_q;
  assign fetch_pc_plus4 = fetch_pc4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit at latencies 0, 3 and 2
module tb_instr_fetch_unit;

  localparam int N = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic        flush = 1'b0;
  logic        pc_we = 1'b0;
  logic [31:0] pc_next = 32'h0;

  logic [31:0] imem_addr [N];
  logic [31:0] rdata     [N];
  logic [31:0] instr     [N];
  logic        ivalid    [N];
  logic [31:0] fpc       [N];
  logic [31:0] fpc4      [N];
  logic        busy      [N];
  logic        fault     [N];

  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign rdata[g] = rom[imem_addr[g][7:2]];
    instr_fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .MEM_LATENCY (g == 0 ? 0 : (g == 1 ? 3 : 2)),
      .NOP_INSTR   (32'h0000_0013)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_req      (fetch_req),
      .flush          (flush),
      .pc_we          (pc_we),
      .pc_next        (pc_next),
      .imem_addr      (imem_addr[g]),
      .instr_rdata    (rdata[g]),
      .instr          (instr[g]),
      .instr_valid    (ivalid[g]),
      .fetch_pc       (fpc[g]),
      .fetch_pc_plus4 (fpc4[g]),
      .fetch_busy     (busy[g]),
      .fetch_fault    (fault[g])
    );
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Reference model: per instance, remaining wait cycles of the fetch in flight
  logic [31:0] m_pc;
  int          m_rem   [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_ir    [N];
  logic [31:0] m_fpc   [N];
  logic [31:0] m_fpc4  [N];
  logic        m_valid [N];
  logic        m_fault [N];

  function automatic int lat(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic logic [31:0] eff_pc(input logic [31:0] pc);
    return TRAP ? pc : {pc[31:2], 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int k = 0; k < N; k++) begin
      m_rem[k] = 0; m_addr[k] = 32'h0; m_ir[k] = NOP;
      m_fpc[k] = 32'h0; m_fpc4[k] = 32'h4; m_valid[k] = 1'b0; m_fault[k] = 1'b0;
    end
  endtask

  task automatic model_capture(input int k, input logic [31:0] a);
    m_ir[k]   = rom[a[7:2]];
    m_fpc[k]  = a;
    m_fpc4[k] = a + 32'd4;
  endtask

  task automatic model_step(input logic req, input logic fl, input logic we, input logic [31:0] nxt);
    for (int k = 0; k < N; k++) begin
      logic nv;
      nv = 1'b0;
      if (fl) begin
        m_rem[k] = 0; m_ir[k] = NOP; m_fault[k] = 1'b0;
      end else if (m_fault[k]) begin
        if (we && nxt[1:0] == 2'b00) m_fault[k] = 1'b0;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          model_capture(k, m_addr[k]);
          nv = 1'b1;
        end
      end else if (req && !(lat(k) == 0 && m_valid[k])) begin
        if (TRAP && m_pc[1:0] != 2'b00) begin
          m_fault[k] = 1'b1;
        end else if (lat(k) == 0) begin
          model_capture(k, eff_pc(m_pc));
          nv = 1'b1;
        end else begin
          m_rem[k]  = lat(k);
          m_addr[k] = eff_pc(m_pc);
        end
      end
      m_valid[k] = nv;
    end
    if (we) m_pc = nxt;
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("d%0d.instr_valid", k), 32'(ivalid[k]), 32'(m_valid[k]));
      check($sformatf("d%0d.instr", k), instr[k], m_ir[k]);
      check($sformatf("d%0d.fetch_pc", k), fpc[k], m_fpc[k]);
      check($sformatf("d%0d.fetch_pc_plus4", k), fpc4[k], m_fpc4[k]);
      check($sformatf("d%0d.fetch_busy", k), 32'(busy[k]), 32'(m_rem[k] > 0));
      check($sformatf("d%0d.fetch_fault", k), 32'(fault[k]), 32'(m_fault[k]));
      check($sformatf("d%0d.imem_addr", k), imem_addr[k],
            (m_rem[k] > 0) ? m_addr[k] : eff_pc(m_pc));
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs
  task automatic step(input logic req, input logic fl, input logic we, input logic [31:0] nxt);
    @(negedge clk);
    check_all();
    fetch_req = req; flush = fl; pc_we = we; pc_next = nxt;
    model_step(req, fl, we, nxt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h0011_0233;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // first fetch at reset PC
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);
    check("d0.word0", instr[0], 32'h0011_0233);
    check("d0.word0_pc4", fpc4[0], 32'h4);

    // fetch at 0x8C with a second request while waiting
    step(1'b0, 1'b0, 1'b1, 32'h8C);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);

    // same-cycle fetch and pc_we
    step(1'b0, 1'b0, 1'b1, 32'hD4);
    step(1'b1, 1'b0, 1'b1, 32'hE4);
    idle(6);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);

    // flush one cycle after the request
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(5);

    // fetch_pc_plus4 wraps
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);
    for (int k = 0; k < N; k++) check($sformatf("d%0d.wrap_pc4", k), fpc4[k], 32'h0);

    // misaligned PC, then realign
    step(1'b0, 1'b0, 1'b1, 32'h1D);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 32'h1C);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);

    // randomized traffic with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] nxt;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) nxt = 32'hFFFF_FFFC;
      else if (sel == 1) nxt = {24'h0, 8'($urandom)};
      else nxt = {24'h0, 6'($urandom), 2'b00};
      if (c == 1500) begin
        step(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        fetch_req = 1'b0; flush = 1'b0; pc_we = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
      end
      step(($urandom % 3) == 0, ($urandom % 12) == 0, ($urandom % 5) == 0, nxt);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
